// File: rtl/data_mem_mmio.sv
// Data-side memory for the RV32I core: byte/half/word RAM with sign/zero
// extension, alignment/legality trapping and a small MMIO register window.
module data_mem_mmio #(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [15:0] MMIO_HI     = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUOut,
  input  logic [31:0] B,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [2:0]  Funct3,
  output logic [31:0] ReadData,
  output logic [7:0]  Led,
  output logic        MemErr
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem_r [DEPTH_WORDS];
  logic [7:0]    led_r;
  logic [31:0]   cycle_r;
  logic [1:0]    status_r;
  logic [31:0]   erraddr_r;
  logic          mem_err_r;

  logic          is_mmio_s;
  logic          access_s;
  logic          ill_s;
  logic          mis_s;
  logic [1:0]    set_s;
  logic          err_s;
  logic          ok_s;
  logic [AW-1:0] idx_s;
  logic [3:0]    be_s;
  logic [31:0]   wdata_s;
  logic          ram_we_s;
  logic          mmio_wr_s;
  logic          led_we_s;
  logic [1:0]    clr_s;
  logic [1:0]    status_nxt_s;
  logic [31:0]   word_s;
  logic [7:0]    byte_s;
  logic [15:0]   half_s;
  logic [31:0]   load_s;
  logic [31:0]   mmio_rd_s;

  // Request decode: window select, legality and alignment classification.
  always_comb begin
    is_mmio_s = (ALUOut[31:16] == MMIO_HI);
    access_s  = MemRead | MemWrite;
    idx_s     = ALUOut[AW+1:2];

    if (MemRead && (Funct3 == 3'b011 || Funct3 == 3'b110 || Funct3 == 3'b111)) begin
      ill_s = 1'b1;
    end else if (MemWrite && (Funct3[2] || Funct3 == 3'b011)) begin
      ill_s = 1'b1;
    end else begin
      ill_s = 1'b0;
    end

    // The MMIO window only accepts word accesses; anything narrower is a misalignment.
    case (Funct3)
      3'b001, 3'b101: mis_s = ALUOut[0];
      3'b010:         mis_s = (ALUOut[1:0] != 2'b00);
      default:        mis_s = 1'b0;
    endcase
    if (is_mmio_s && Funct3 != 3'b010) begin
      mis_s = 1'b1;
    end else begin
      mis_s = mis_s;
    end

    // An illegal encoding is reported as ILL only, never also as MIS.
    set_s = {access_s & ill_s, access_s & ~ill_s & mis_s};
    err_s = |set_s;
    ok_s  = access_s & ~err_s;
  end

  // Store lane enables and lane-replicated store data.
  always_comb begin
    case (Funct3[1:0])
      2'b00: begin
        be_s    = 4'b0001 << ALUOut[1:0];
        wdata_s = {4{B[7:0]}};
      end
      2'b01: begin
        be_s    = ALUOut[1] ? 4'b1100 : 4'b0011;
        wdata_s = {2{B[15:0]}};
      end
      default: begin
        be_s    = 4'b1111;
        wdata_s = B;
      end
    endcase
    ram_we_s  = MemWrite & ok_s & ~is_mmio_s;
    mmio_wr_s = MemWrite & ok_s & is_mmio_s;
    led_we_s  = mmio_wr_s & (ALUOut[15:0] == 16'h0000);
    if (mmio_wr_s && ALUOut[15:0] == 16'h0008) begin
      clr_s = B[1:0];
    end else begin
      clr_s = 2'b00;
    end
    status_nxt_s = (status_r & ~clr_s) | set_s;
  end

  // Load path: lane select, extension and MMIO register read mux.
  always_comb begin
    word_s = mem_r[idx_s];
    case (ALUOut[1:0])
      2'b00:   byte_s = word_s[7:0];
      2'b01:   byte_s = word_s[15:8];
      2'b10:   byte_s = word_s[23:16];
      default: byte_s = word_s[31:24];
    endcase
    half_s = ALUOut[1] ? word_s[31:16] : word_s[15:0];
    case (Funct3)
      3'b000:  load_s = {{24{byte_s[7]}}, byte_s};
      3'b001:  load_s = {{16{half_s[15]}}, half_s};
      3'b100:  load_s = {24'h000000, byte_s};
      3'b101:  load_s = {16'h0000, half_s};
      default: load_s = word_s;
    endcase
    case (ALUOut[15:0])
      16'h0000: mmio_rd_s = {24'h000000, led_r};
      16'h0004: mmio_rd_s = cycle_r;
      16'h0008: mmio_rd_s = {30'h00000000, status_r};
      16'h000C: mmio_rd_s = erraddr_r;
      default:  mmio_rd_s = 32'h00000000;
    endcase
    if (MemRead && ok_s) begin
      ReadData = is_mmio_s ? mmio_rd_s : load_s;
    end else begin
      ReadData = 32'h00000000;
    end
  end

  // RAM array; not reset, and a store landing on an edge with rst high is dropped.
  always_ff @(posedge clk) begin
    if (ram_we_s && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          mem_r[idx_s][8*i +: 8] <= wdata_s[8*i +: 8];
        end
      end
    end
  end

  // MMIO registers, sticky error status and registered error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_r     <= 8'h00;
      cycle_r   <= 32'h00000000;
      status_r  <= 2'b00;
      erraddr_r <= 32'h00000000;
      mem_err_r <= 1'b0;
    end else begin
      cycle_r   <= cycle_r + 32'd1;
      status_r  <= status_nxt_s;
      mem_err_r <= |status_nxt_s;
      if (led_we_s) begin
        led_r <= B[7:0];
      end
      if (err_s && status_r == 2'b00) begin
        erraddr_r <= ALUOut;
      end
    end
  end

  assign Led    = led_r;
  assign MemErr = mem_err_r;

endmodule

// File: doc/data_mem_mmio.md
# data_mem_mmio

Data-side memory for the 5-stage RV32I core. It consumes the Memory-stage request (address, store data, MemRead/MemWrite, funct3) and returns load data to the MEM/WB pipeline register in the same cycle. It replaces the word-only data memory with byte/half/word accesses, sign/zero extension, misalignment trapping, and a small memory-mapped I/O window (LED register, cycle counter, error status).

## Interface
- DEPTH_WORDS, 256: RAM depth in 32-bit words; power of two, at least 4.
- MMIO_HI, 16'hFFFF: value of ALUOut[31:16] that selects the MMIO window.

- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- ALUOut  in  32  byte address from the Memory stage.
- B  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- MemWrite  in  1  store request this cycle.
- MemRead  in  1  load request this cycle.
- Funct3  in  3  access size and sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- ReadData  out  32  extended load data; combinational.
- Led  out  8  LED register contents.
- MemErr  out  1  OR of the STATUS error bits.

## Operation
- Decode:
  - ALUOut[31:16]==MMIO_HI selects MMIO. Any other address selects RAM.
  - RAM word index is ALUOut[log2(DEPTH_WORDS)+1:2]. Higher address bits are ignored, so addresses alias and wrap modulo DEPTH_WORDS*4.
- RAM stores:
  - The byte-lane write enable comes from size and ALUOut[1:0].
  - sb writes lane addr[1:0] with B[7:0].
  - sh writes lanes {addr[1],0} and +1 with B[15:0], little-endian.
  - sw writes all four lanes.
  - Other lanes are unchanged.
- RAM loads:
  - Select the byte or half using addr[1:0].
  - b and h sign-extend from bit 7 or bit 15; bu and hu zero-extend.
- Illegal access:
  - Condition: a load with Funct3 ∈ {011,110,111}, or a store with Funct3[2]==1 or Funct3==011.
  - The access is suppressed, ReadData=0, and STATUS.ILL is set.
- Misaligned access:
  - Condition: h/hu with addr[0]=1, or w with addr[1:0]≠0.
  - The access is suppressed, ReadData=0, and STATUS.MIS is set.
- MMIO:
  - Word accesses only. Funct3≠010 in the window is treated as misaligned.
  - Offset 0x00 LED (RW): bits [7:0] drive Led; reads return zero-extended.
  - Offset 0x04 CYCLE (RO): 32-bit count of clock edges since reset; wraps 0xFFFFFFFF→0; writes ignored.
  - Offset 0x08 STATUS: bit0 MIS, bit1 ILL. Both are sticky. Writing 1 clears a bit (W1C).
  - Offset 0x0C ERRADDR (RO): ALUOut of the first error since STATUS last became 0.
  - Any other offset: read 0, write ignored, no error.
- Error capture:
  - ERRADDR loads only when STATUS==0 and an error occurs.
  - If an error and a W1C of the same bit happen in the same cycle, set wins.
- MemRead and MemWrite both high:
  - The store is performed.
  - ReadData returns the pre-write contents at that address.
  - No error is raised for the combination itself.
- MemRead=0: ReadData=0.
- Error checks apply only when MemRead or MemWrite is high.

## Timing
- Load latency 0: ReadData is a combinational function of the inputs and current array/register state, valid in the same cycle for the MEM/WB register.
- Stores and MMIO register writes take effect at the rising clk edge ending the request cycle. A load of the same address in the next cycle sees the new data.
- Read during write to the same word in the same cycle returns old data.
- CYCLE increments on every edge while rst=0, including cycles with MMIO accesses. A read of CYCLE returns the value before that cycle's increment.
- Reset (asynchronous, any time, including mid-access):
  - Immediately: Led=0, CYCLE=0, STATUS=0, ERRADDR=0, MemErr=0.
  - A store coincident with reset assertion is dropped.
  - RAM contents are not cleared by reset.
- MemErr is registered: it rises the edge after the offending request.

## Test plan
- Byte/half stores with sign extension:
  - Stimulus: sw 0x11223344 @0x10, then sb 0x80 @0x11, then sh 0xBEEF @0x12.
  - Required: lw @0x10 → 0xBEEF8044; lb @0x11 → 0xFFFFFF80; lbu @0x11 → 0x00000080; lh @0x12 → 0xFFFFBEEF.
- Misaligned word store:
  - Stimulus: sw @0x21.
  - Required: memory unchanged, STATUS=0x1, ERRADDR=0x21, MemErr=1 next cycle.
  - Then lh @0x33: STATUS stays 0x1, ERRADDR stays 0x21.
  - Then sw 0x1 to 0xFFFF0008: STATUS=0, MemErr=0.
- Simultaneous set and clear: an illegal load (Funct3=111) in the same cycle as a W1C write of 0x2 → STATUS.ILL=1 after the edge.
- Aliasing and wrap (DEPTH_WORDS=256):
  - sw 0xCAFEF00D @0x400 → lw @0x000 returns 0xCAFEF00D.
  - Read-during-write: MemRead=MemWrite=1 @0x0 with B=0x5 → ReadData=0xCAFEF00D; next-cycle lw returns 0x5.
- MMIO:
  - sw 0x1A5 to 0xFFFF0000 → Led=0xA5.
  - Two lw of 0xFFFF0004 three cycles apart → values differ by 3.
  - sb to 0xFFFF0000 → Led unchanged, STATUS.MIS=1.
- Reset mid-operation: assert rst asynchronously between edges while sw to LED is pending → Led=0 and STATUS=0 immediately, write lost; previously stored RAM word still reads back after deassertion.
